// File: rtl/sys_pkg.sv
// Shared types and defaults for the HPS download controller: FSM state
// encoding, default sizing, and the address range test.
package sys_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } dn_state_e;

  localparam int DEF_RESET_HOLD = 16;
  localparam int DEF_ADDR_W     = 17;

  // True when every byte-address bit above the target bus width is zero.
  function automatic logic addr_in_range(input logic [24:0] addr, input int unsigned aw);
    return (addr >> aw) == 25'd0;
  endfunction

endpackage

// File: rtl/dn_loader_ctrl_if.sv
// Loader-side and target-side signals of the download controller.
// master = HPS loader / system wrapper, slave = dn_loader_ctrl.
interface dn_loader_ctrl_if #(
  parameter int ADDR_W = sys_pkg::DEF_ADDR_W
) ();
  logic              ce;
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [7:0]        ioctl_index;
  logic              ioctl_wait;
  logic [ADDR_W-1:0] dn_addr;
  logic [7:0]        dn_data;
  logic [7:0]        dn_index;
  logic              dn_wr;
  logic              sys_reset;
  logic              addr_err;
  logic              overrun;
  logic [ADDR_W:0]   dn_count;

  modport master (
    output ce, ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    input  ioctl_wait, dn_addr, dn_data, dn_index, dn_wr, sys_reset,
           addr_err, overrun, dn_count
  );

  modport slave (
    input  ce, ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    output ioctl_wait, dn_addr, dn_data, dn_index, dn_wr, sys_reset,
           addr_err, overrun, dn_count
  );
endinterface

// File: rtl/dn_hold_timer.sv
// Down-counter that times how long the core stays in reset after a download.
// done_o is high on the last cycle of the hold window.
module dn_hold_timer #(
  parameter int RESET_HOLD = sys_pkg::DEF_RESET_HOLD
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic load_i,
  input  logic tick_i,
  output logic done_o
);

  localparam int CW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(RESET_HOLD - 1);

  logic [CW-1:0] cnt_q;

  // Reload on entry to the hold window, then count down to zero and stop.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_q <= LOAD_VAL;
    end else if (load_i) begin
      cnt_q <= LOAD_VAL;
    end else if (tick_i && (cnt_q != {CW{1'b0}})) begin
      cnt_q <= cnt_q - CW'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign done_o = (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/dn_loader_ctrl.sv
// HPS download controller: buffers one loader byte at a time, replays it to
// the target RAMs on a ce slot, and holds the core in reset around the session.
module dn_loader_ctrl
  import sys_pkg::*;
#(
  parameter int RESET_HOLD = DEF_RESET_HOLD,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input logic             clk_sys,
  input logic             reset,
  dn_loader_ctrl_if.slave bus
);

  localparam logic [ADDR_W:0] CNT_MAX = {(ADDR_W + 1){1'b1}};

  dn_state_e         state_q, state_d;
  logic              dl_prev_q;
  logic              buf_full_q;
  logic [ADDR_W-1:0] buf_addr_q;
  logic [7:0]        buf_data_q;
  logic [7:0]        buf_index_q;
  logic              wait_q;
  logic              dn_wr_q;
  logic [ADDR_W-1:0] dn_addr_q;
  logic [7:0]        dn_data_q;
  logic [7:0]        dn_index_q;
  logic              sys_reset_q;
  logic              addr_err_q;
  logic              overrun_q;
  logic [ADDR_W:0]   dn_count_q;

  logic dl_rise, wr_load, addr_ok, capture, issue, buf_full_nx;
  logic enter_load, timer_load, timer_done;

  assign dl_rise     = bus.ioctl_download & ~dl_prev_q;
  assign wr_load     = (state_q == ST_LOAD) & bus.ioctl_wr;
  assign addr_ok     = addr_in_range(bus.ioctl_addr, ADDR_W);
  assign capture     = wr_load & addr_ok & ~buf_full_q;
  // dn_wr is registered, so it appears in the cycle after the ce slot that issues it.
  assign issue       = buf_full_q & bus.ce;
  assign buf_full_nx = capture | (buf_full_q & ~issue);
  assign enter_load  = (state_d == ST_LOAD) & (state_q != ST_LOAD);
  assign timer_load  = (state_d == ST_HOLD) & (state_q != ST_HOLD);

  dn_hold_timer #(
    .RESET_HOLD(RESET_HOLD)
  ) u_hold_timer (
    .clk_sys(clk_sys),
    .reset  (reset),
    .load_i (timer_load),
    .tick_i (state_q == ST_HOLD),
    .done_o (timer_done)
  );

  // Session sequencing; a fresh download rise always wins over hold expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (dl_rise) state_d = ST_LOAD;
        else         state_d = ST_IDLE;
      end
      ST_LOAD: begin
        if (!bus.ioctl_download) state_d = buf_full_nx ? ST_DRAIN : ST_HOLD;
        else                     state_d = ST_LOAD;
      end
      ST_DRAIN: begin
        if (issue) state_d = ST_HOLD;
        else       state_d = ST_DRAIN;
      end
      ST_HOLD: begin
        if (dl_rise)         state_d = ST_LOAD;
        else if (timer_done) state_d = ST_IDLE;
        else                 state_d = ST_HOLD;
      end
      default: state_d = ST_HOLD;
    endcase
  end

  // State, one-entry buffer, target write port and status flags.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= ST_HOLD;
      dl_prev_q   <= 1'b0;
      buf_full_q  <= 1'b0;
      buf_addr_q  <= {ADDR_W{1'b0}};
      buf_data_q  <= 8'd0;
      buf_index_q <= 8'd0;
      wait_q      <= 1'b0;
      dn_wr_q     <= 1'b0;
      dn_addr_q   <= {ADDR_W{1'b0}};
      dn_data_q   <= 8'd0;
      dn_index_q  <= 8'd0;
      sys_reset_q <= 1'b1;
      addr_err_q  <= 1'b0;
      overrun_q   <= 1'b0;
      dn_count_q  <= {(ADDR_W + 1){1'b0}};
    end else begin
      state_q     <= state_d;
      dl_prev_q   <= bus.ioctl_download;
      buf_full_q  <= buf_full_nx;
      wait_q      <= buf_full_nx;
      sys_reset_q <= (state_d != ST_IDLE);
      dn_wr_q     <= issue;

      if (capture) begin
        buf_addr_q  <= bus.ioctl_addr[ADDR_W-1:0];
        buf_data_q  <= bus.ioctl_dout;
        buf_index_q <= bus.ioctl_index;
      end

      if (issue) begin
        dn_addr_q  <= buf_addr_q;
        dn_data_q  <= buf_data_q;
        dn_index_q <= buf_index_q;
      end

      if (enter_load) begin
        addr_err_q <= 1'b0;
        overrun_q  <= 1'b0;
        dn_count_q <= {(ADDR_W + 1){1'b0}};
      end else begin
        if (wr_load && !addr_ok)    addr_err_q <= 1'b1;
        if (wr_load && buf_full_q)  overrun_q  <= 1'b1;
        if (issue && (dn_count_q != CNT_MAX)) dn_count_q <= dn_count_q + {{ADDR_W{1'b0}}, 1'b1};
      end
    end
  end

  assign bus.ioctl_wait = wait_q;
  assign bus.dn_wr      = dn_wr_q;
  assign bus.dn_addr    = dn_addr_q;
  assign bus.dn_data    = dn_data_q;
  assign bus.dn_index   = dn_index_q;
  assign bus.sys_reset  = sys_reset_q;
  assign bus.addr_err   = addr_err_q;
  assign bus.overrun    = overrun_q;
  assign bus.dn_count   = dn_count_q;

endmodule

// File: tb/tb_dn_loader_ctrl.sv
// Bench for dn_loader_ctrl: directed scenarios plus randomized sessions, all
// compared each cycle against a queue-based behavioural model.
module tb_dn_loader_ctrl;
  import sys_pkg::*;

  localparam int RH = 16;
  localparam int AW = 17;

  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  dn_loader_ctrl_if #(.ADDR_W(AW)) bus ();

  dn_loader_ctrl #(.RESET_HOLD(RH), .ADDR_W(AW)) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;
  bit chk_en = 1'b0;
  int ce_mode = 0;
  int ce_div = 0;
  logic ce_last = 1'b0;
  int pulse_cnt = 0;
  bit meas_wait = 1'b0;
  int wait_run = 0;

  typedef struct {
    logic [24:0] a;
    logic [7:0]  d;
    logic [7:0]  i;
  } ent_t;

  // Behavioural model: session / drain / remaining-hold-cycles plus a pending queue.
  bit              m_sess = 1'b0;
  bit              m_drain = 1'b0;
  int              m_hold = 0;
  bit              m_prev_dl = 1'b0;
  ent_t            m_q[$];
  logic            m_wr = 1'b0;
  logic [AW-1:0]   m_addr = '0;
  logic [7:0]      m_data = 8'd0;
  logic [7:0]      m_idx = 8'd0;
  logic [AW:0]     m_cnt = '0;
  bit              m_aerr = 1'b0;
  bit              m_ovr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic issue_one();
    ent_t e;
    e = m_q.pop_front();
    m_wr   = 1'b1;
    m_addr = e.a[AW-1:0];
    m_data = e.d;
    m_idx  = e.i;
    if (m_cnt != {(AW + 1){1'b1}}) m_cnt = m_cnt + 1'b1;
  endtask

  task automatic model_step();
    bit   rise;
    bit   full;
    ent_t e;
    if (reset) begin
      m_sess = 1'b0; m_drain = 1'b0; m_hold = RH; m_q.delete(); m_prev_dl = 1'b0;
      m_wr = 1'b0; m_addr = '0; m_data = 8'd0; m_idx = 8'd0; m_cnt = '0;
      m_aerr = 1'b0; m_ovr = 1'b0;
      return;
    end
    rise = bus.ioctl_download && !m_prev_dl;
    m_prev_dl = bus.ioctl_download;
    m_wr = 1'b0;
    if (m_sess) begin
      full = (m_q.size() != 0);
      if (full && bus.ce) issue_one();
      if (bus.ioctl_wr) begin
        if ((bus.ioctl_addr >> AW) != 25'd0) m_aerr = 1'b1;
        else if (!full) begin
          e.a = bus.ioctl_addr; e.d = bus.ioctl_dout; e.i = bus.ioctl_index;
          m_q.push_back(e);
        end
        if (full) m_ovr = 1'b1;
      end
      if (!bus.ioctl_download) begin
        m_sess = 1'b0;
        if (m_q.size() != 0) m_drain = 1'b1;
        else m_hold = RH;
      end
    end else if (m_drain) begin
      if (bus.ce) begin
        issue_one();
        m_drain = 1'b0;
        m_hold = RH;
      end
    end else if (rise) begin
      m_sess = 1'b1; m_hold = 0; m_aerr = 1'b0; m_ovr = 1'b0; m_cnt = '0;
    end else if (m_hold > 0) begin
      m_hold--;
    end
  endtask

  initial forever begin
    @(posedge clk_sys);
    model_step();
  end

  // ce generator: 0 = every 4th cycle, 1 = random, otherwise held low.
  initial begin
    bus.ce = 1'b0;
    forever begin
      @(posedge clk_sys);
      #1;
      ce_div = (ce_div + 1) % 4;
      case (ce_mode)
        0:       bus.ce = (ce_div == 0);
        1:       bus.ce = ($urandom_range(0, 2) == 0);
        default: bus.ce = 1'b0;
      endcase
    end
  end

  // Per-cycle comparison against the model, on the inactive clock edge.
  initial forever begin
    @(negedge clk_sys);
    if (chk_en) begin
      chk("ioctl_wait", 32'(bus.ioctl_wait), 32'(m_q.size() != 0));
      chk("dn_wr",      32'(bus.dn_wr),      32'(m_wr));
      chk("dn_addr",    32'(bus.dn_addr),    32'(m_addr));
      chk("dn_data",    32'(bus.dn_data),    32'(m_data));
      chk("dn_index",   32'(bus.dn_index),   32'(m_idx));
      chk("sys_reset",  32'(bus.sys_reset),  32'(m_sess || m_drain || (m_hold > 0)));
      chk("addr_err",   32'(bus.addr_err),   32'(m_aerr));
      chk("overrun",    32'(bus.overrun),    32'(m_ovr));
      chk("dn_count",   32'(bus.dn_count),   32'(m_cnt));
      if (bus.dn_wr) begin
        pulse_cnt++;
        chk("wr_follows_ce", 32'(ce_last), 32'd1);
      end
      if (meas_wait) begin
        if (bus.ioctl_wait) wait_run++;
        else if (wait_run != 0) begin
          chk("wait_run_1_to_4", 32'((wait_run >= 1) && (wait_run <= 4)), 32'd1);
          wait_run = 0;
        end
      end
    end
    ce_last = bus.ce;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic start_dl();
    bus.ioctl_download = 1'b1;
    tick(1);
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d, input logic [7:0] i);
    int guard = 0;
    while (bus.ioctl_wait && guard < 20) begin
      tick(1);
      guard++;
    end
    if (guard >= 20) chk("wait_release", 32'(bus.ioctl_wait), 32'd0);
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = a; bus.ioctl_dout = d; bus.ioctl_index = i;
    tick(1);
    bus.ioctl_wr = 1'b0;
  endtask

  initial begin
    int p0;
    int n;
    logic [24:0] a;
    reset = 1'b1;
    bus.ioctl_download = 1'b0; bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = 25'd0; bus.ioctl_dout = 8'd0; bus.ioctl_index = 8'd0;
    tick(1);
    chk_en = 1'b1;
    tick(2);
    chk("rst_sys_reset", 32'(bus.sys_reset), 32'd1);
    chk("rst_wait", 32'(bus.ioctl_wait), 32'd0);
    chk("rst_count", 32'(bus.dn_count), 32'd0);
    reset = 1'b0;
    tick(RH + 2);
    chk("post_rst_sys_reset", 32'(bus.sys_reset), 32'd0);

    // Four bytes with ce every 4th cycle.
    ce_mode = 0; p0 = pulse_cnt; meas_wait = 1'b1;
    start_dl();
    for (int i = 0; i < 4; i++) wr_byte(25'(i), 8'hA0 + 8'(i), 8'd0);
    tick(8);
    meas_wait = 1'b0;
    chk("t1_pulses", 32'(pulse_cnt - p0), 32'd4);
    chk("t1_count", 32'(bus.dn_count), 32'd4);
    chk("t1_model_count", 32'(m_cnt), 32'd4);
    chk("t1_last_addr", 32'(bus.dn_addr), 32'd3);
    chk("t1_last_data", 32'(bus.dn_data), 32'hA3);
    bus.ioctl_download = 1'b0;
    tick(RH + 4);

    // Out-of-range address.
    start_dl();
    p0 = pulse_cnt;
    wr_byte(25'h20000, 8'h55, 8'd1);
    tick(8);
    chk("t2_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    chk("t2_addr_err", 32'(bus.addr_err), 32'd1);
    bus.ioctl_download = 1'b0;
    tick(RH + 4);
    chk("t2_addr_err_sticky", 32'(bus.addr_err), 32'd1);
    start_dl();
    chk("t2_addr_err_clear", 32'(bus.addr_err), 32'd0);

    // Back-to-back writes with ce low.
    ce_mode = 2; tick(2); p0 = pulse_cnt;
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'd5; bus.ioctl_dout = 8'h55; bus.ioctl_index = 8'd2;
    tick(1);
    bus.ioctl_addr = 25'd6; bus.ioctl_dout = 8'h66;
    tick(1);
    bus.ioctl_wr = 1'b0;
    tick(3);
    chk("t3_overrun", 32'(bus.overrun), 32'd1);
    chk("t3_model_overrun", 32'(m_ovr), 32'd1);
    chk("t3_wait_full", 32'(bus.ioctl_wait), 32'd1);
    ce_mode = 0;
    tick(8);
    chk("t3_pulses", 32'(pulse_cnt - p0), 32'd1);
    chk("t3_addr", 32'(bus.dn_addr), 32'd5);
    chk("t3_data", 32'(bus.dn_data), 32'h55);

    // Write on the download fall, ce held low, then drain and hold.
    ce_mode = 2; tick(2);
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'd7; bus.ioctl_dout = 8'h77; bus.ioctl_index = 8'd4;
    bus.ioctl_download = 1'b0;
    tick(1);
    bus.ioctl_wr = 1'b0;
    tick(4);
    chk("t4_drain_sys_reset", 32'(bus.sys_reset), 32'd1);
    ce_mode = 0;
    n = 0;
    while (!bus.dn_wr && n < 20) begin tick(1); n++; end
    chk("t4_dn_wr", 32'(bus.dn_wr), 32'd1);
    chk("t4_data", 32'(bus.dn_data), 32'h77);
    n = 0;
    while (bus.sys_reset && n < 40) begin n++; tick(1); end
    chk("t4_hold_len", 32'(n), 32'd16);

    // Re-rise five cycles into hold.
    start_dl();
    wr_byte(25'd1, 8'h11, 8'd0);
    tick(6);
    chk("t5_count_before", 32'(bus.dn_count), 32'd1);
    bus.ioctl_download = 1'b0;
    tick(5);
    bus.ioctl_download = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk("t5_sys_reset_held", 32'(bus.sys_reset), 32'd1);
    end
    chk("t5_count_cleared", 32'(bus.dn_count), 32'd0);

    // Reset while the buffer is full.
    ce_mode = 2; tick(2);
    wr_byte(25'd10, 8'hCC, 8'd3);
    tick(2);
    chk("t6_wait_full", 32'(bus.ioctl_wait), 32'd1);
    p0 = pulse_cnt;
    reset = 1'b1; bus.ioctl_download = 1'b0;
    tick(1);
    reset = 1'b0;
    chk("t6_wait_cleared", 32'(bus.ioctl_wait), 32'd0);
    ce_mode = 0;
    n = 0;
    while (bus.sys_reset && n < 40) begin n++; tick(1); end
    chk("t6_hold_len", 32'(n), 32'd16);
    chk("t6_no_pulse", 32'(pulse_cnt - p0), 32'd0);

    // Randomized sessions.
    ce_mode = 1;
    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(0, 14) == 0) begin
        reset = 1'b1; tick(1); reset = 1'b0;
      end
      bus.ioctl_download = 1'b1;
      for (int c = 0, len = $urandom_range(5, 40); c < len; c++) begin
        bus.ioctl_wr = ($urandom_range(0, 2) == 0) && (!bus.ioctl_wait || $urandom_range(0, 5) == 0);
        if ($urandom_range(0, 7) == 0) begin
          a = 25'($urandom);
          a = a | (25'd1 << $urandom_range(AW, 24));
        end else begin
          a = 25'($urandom_range(0, (1 << AW) - 1));
        end
        bus.ioctl_addr = a; bus.ioctl_dout = 8'($urandom); bus.ioctl_index = 8'($urandom);
        reset = ($urandom_range(0, 199) == 0);
        tick(1);
        reset = 1'b0;
      end
      bus.ioctl_download = 1'b0;
      for (int g = 0, gap = $urandom_range(1, 26); g < gap; g++) begin
        bus.ioctl_wr = ($urandom_range(0, 3) == 0);
        bus.ioctl_addr = 25'($urandom_range(0, 255));
        tick(1);
      end
      bus.ioctl_wr = 1'b0;
    end
    tick(RH + 8);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/dn_loader_ctrl.md
DN_LOADER_CTRL -- requirements
Module: dn_loader_ctrl

Interface
REQ-001 Parameter RESET_HOLD, default 16: clk_sys cycles that sys_reset stays high after a download ends.
REQ-002 Parameter ADDR_W, default 17: width of the target address bus.
REQ-003 clk_sys  in  1  system clock; only clock in the block.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ce  in  1  write-slot enable; target RAMs accept writes only on ce=1 cycles (driven from ce_6).
REQ-006 ioctl_download  in  1  download session active.
REQ-007 ioctl_wr  in  1  one-cycle write strobe from the HPS loader.
REQ-008 ioctl_addr  in  25  byte address.
REQ-009 ioctl_dout  in  8  byte data.
REQ-010 ioctl_index  in  8  target selector.
REQ-011 ioctl_wait  out  1  backpressure to the loader; high while the buffer is full.
REQ-012 dn_addr  out  ADDR_W  target address.
REQ-013 dn_data  out  8  target data.
REQ-014 dn_index  out  8  target selector.
REQ-015 dn_wr  out  1  one-cycle target write strobe.
REQ-016 sys_reset  out  1  reset to the system core.
REQ-017 addr_err  out  1  sticky flag: out-of-range address seen.
REQ-018 overrun  out  1  sticky flag: write arrived while the buffer was full.
REQ-019 dn_count  out  ADDR_W+1  bytes written this session, saturating.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, DRAIN and HOLD.
REQ-021 IDLE: sys_reset=0. An ioctl_download rise SHALL enter LOAD on the next cycle.
REQ-022 Entering LOAD SHALL clear addr_err, overrun and dn_count; sys_reset=1 throughout LOAD, DRAIN and HOLD.
REQ-023 LOAD: an ioctl_wr with the buffer empty SHALL capture addr/dout/index into a one-entry buffer, and ioctl_wait SHALL go high the next cycle.
REQ-024 A full buffer SHALL issue on the first cycle with ce=1 at or after the cycle following capture.
- Issue = registered dn_wr pulse of exactly one cycle; dn_addr/dn_data/dn_index valid in that cycle.
- Buffer empties at issue; ioctl_wait low on the cycle after issue.
REQ-025 An ioctl_wr with ioctl_addr[24:ADDR_W] nonzero SHALL be dropped (not captured) and SHALL set addr_err.
REQ-026 An ioctl_wr while the buffer is full SHALL be dropped and SHALL set overrun; the buffered entry is unaffected.
REQ-027 dn_count SHALL increment on each dn_wr and saturate at all-ones.
REQ-028 ioctl_download fall SHALL go to DRAIN if the buffer is full, else to HOLD.
REQ-029 An ioctl_wr in the same cycle as the download fall SHALL be captured, then DRAIN.
REQ-030 DRAIN SHALL issue the buffered write per REQ-024, then go to HOLD.
REQ-031 HOLD SHALL load a counter with RESET_HOLD-1, decrement it each cycle, and go to IDLE after RESET_HOLD cycles.
REQ-032 An ioctl_download rise during HOLD SHALL go directly to LOAD; the counter is abandoned.
REQ-033 An ioctl_wr while ioctl_download=0 and the state is IDLE or HOLD SHALL be ignored.
REQ-034 dn_addr, dn_data and dn_index SHALL hold their last issued values when dn_wr=0.

Reset
REQ-035 reset SHALL force state HOLD with the counter at RESET_HOLD-1, and set:
- sys_reset=1, buffer empty, ioctl_wait=0, dn_wr=0;
- dn_addr, dn_data, dn_index, dn_count = 0;
- addr_err=0, overrun=0.
REQ-036 reset during LOAD SHALL discard any buffered write; no dn_wr SHALL be issued for it.

Structure
REQ-037 The FSM state enum and the default RESET_HOLD/ADDR_W constants SHALL live in shared package sys_pkg.
REQ-038 One sub-module, dn_hold_timer, SHALL provide the HOLD down-counter (load, tick, done); all else is flat.

Verification
REQ-039 ce every 4th cycle; download with 4 writes to addr 0..3, data A0..A3, index 0 -> 4 dn_wr pulses each aligned to ce; dn_count=4; ioctl_wait high 1-4 cycles per byte.
REQ-040 ioctl_wr addr 0x20000 -> no dn_wr; addr_err=1 until the next download start.
REQ-041 Two ioctl_wr on consecutive cycles with ce=0 -> first byte issued, second dropped; overrun=1.
REQ-042 ioctl_wr in the same cycle as the download fall, ce held 0 for 5 cycles -> DRAIN, dn_wr on the first ce, then sys_reset high for exactly 16 cycles, then low.
REQ-043 Download re-asserted 5 cycles into HOLD -> LOAD next cycle; sys_reset stays high continuously; dn_count=0.
REQ-044 reset pulsed with the buffer full -> no dn_wr; ioctl_wait=0 next cycle; sys_reset low after 16 cycles.
